decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage.sv | 257 +++++++++++++++++++++++++
 tb/tb_decode_stage.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// decode_stage: RV32 decoder feeding a small FIFO of decoded records.
// Illegal words are queued as SYS records with n_bad_inst low.
module decode_stage #(
  parameter int DEPTH = 2,
  parameter bit EN_M  = 1'b1,
  parameter bit EN_A  = 1'b1,
  parameter bit EN_F  = 1'b1
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            instruction,
  input  logic [31:0]            pc,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [1:0]             unit,
  output logic [2:0]             funct3,
  output logic [6:0]             funct7,
  output logic [4:0]             reg_d,
  output logic [4:0]             reg_s1,
  output logic [4:0]             reg_s2,
  output logic [4:0]             reg_s3,
  output logic                   rd_we,
  output logic [31:0]            immed,
  output logic [31:0]            pc_out,
  output logic                   n_bad_inst,
  output logic [$clog2(DEPTH):0] occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;
  localparam logic [OW-1:0] FULL = OW'(DEPTH);

  localparam logic [6:0] OP_OP    = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_ST    = 7'b0100011;
  localparam logic [6:0] OP_AMO   = 7'b0101111;
  localparam logic [6:0] OP_FLD   = 7'b0000111;
  localparam logic [6:0] OP_FST   = 7'b0100111;
  localparam logic [6:0] OP_FMA0  = 7'b1000011;
  localparam logic [6:0] OP_FMA1  = 7'b1000111;
  localparam logic [6:0] OP_FMA2  = 7'b1001011;
  localparam logic [6:0] OP_FMA3  = 7'b1001111;
  localparam logic [6:0] OP_FP    = 7'b1010011;
  localparam logic [6:0] OP_MISC  = 7'b0001111;
  localparam logic [6:0] OP_SYS   = 7'b1110011;

  localparam logic [1:0] U_ALU = 2'd0;
  localparam logic [1:0] U_MEM = 2'd1;
  localparam logic [1:0] U_FPU = 2'd2;
  localparam logic [1:0] U_SYS = 2'd3;

  typedef enum logic [2:0] {
    F_R, F_I, F_S, F_B, F_U, F_J
  } fmt_t;

  typedef struct packed {
    logic [1:0]  unit;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rs3;
    logic        rd_we;
    logic [31:0] immed;
    logic [31:0] pc;
    logic        ok;
  } rec_t;

  rec_t          dec;
  rec_t          head;
  rec_t          mem [DEPTH];
  fmt_t          fmt;
  logic          ok;
  logic          r4;
  logic          int_we;
  logic          fp_int;
  logic [6:0]    opc;
  logic [6:0]    f7;
  logic [2:0]    f3;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [OW-1:0] occ;
  logic          push;
  logic          pop;

  assign opc    = instruction[6:0];
  assign f7     = instruction[31:25];
  assign f3     = instruction[14:12];
  assign int_we = (instruction[11:7] != 5'd0);
  assign fp_int = (f7[6:2] == 5'b10100) ||
                  (f7[6:2] == 5'b11000) ||
                  (f7[6:2] == 5'b11100);

  // combinational decode of the incoming word into a queue record
  always_comb begin
    dec        = '0;
    dec.funct3 = f3;
    dec.funct7 = f7;
    dec.rd     = instruction[11:7];
    dec.rs1    = instruction[19:15];
    dec.rs2    = instruction[24:20];
    dec.pc     = pc;
    dec.unit   = U_ALU;
    ok         = 1'b1;
    r4         = 1'b0;
    fmt        = F_R;
    case (opc)
      OP_OP: begin
        dec.rd_we = int_we;
        if (!EN_M && f7 == 7'b0000001) ok = 1'b0;
      end
      OP_IMM: begin
        fmt       = F_I;
        dec.rd_we = int_we;
        if ((f3 == 3'b001 || f3 == 3'b101) &&
            !(f7 == 7'b0000000 || f7 == 7'b0100000))
          ok = 1'b0;
      end
      OP_LUI, OP_AUIPC: begin
        fmt       = F_U;
        dec.rd_we = int_we;
      end
      OP_JAL: begin
        fmt       = F_J;
        dec.rd_we = int_we;
      end
      OP_JALR: begin
        fmt       = F_I;
        dec.rd_we = int_we;
      end
      OP_BR: fmt = F_B;
      OP_LD: begin
        fmt       = F_I;
        dec.unit  = U_MEM;
        dec.rd_we = int_we;
      end
      OP_ST: begin
        fmt      = F_S;
        dec.unit = U_MEM;
      end
      OP_AMO: begin
        dec.unit  = U_MEM;
        dec.rd_we = int_we;
        ok        = EN_A;
      end
      OP_FLD: begin
        fmt       = F_I;
        dec.unit  = U_MEM;
        dec.rd_we = 1'b1;
        ok        = EN_F;
      end
      OP_FST: begin
        fmt      = F_S;
        dec.unit = U_MEM;
        ok       = EN_F;
      end
      OP_FMA0, OP_FMA1, OP_FMA2, OP_FMA3: begin
        r4        = 1'b1;
        dec.unit  = U_FPU;
        dec.rd_we = 1'b1;
        ok        = EN_F;
      end
      OP_FP: begin
        dec.unit  = U_FPU;
        dec.rd_we = fp_int ? int_we : 1'b1;
        ok        = EN_F;
      end
      OP_MISC: begin
        fmt      = F_I;
        dec.unit = U_SYS;
      end
      OP_SYS: begin
        fmt       = F_I;
        dec.unit  = U_SYS;
        dec.rd_we = int_we;
      end
      default: ok = 1'b0;
    endcase
    if (instruction[1:0] != 2'b11 ||
        instruction == 32'h0 ||
        instruction == 32'hFFFF_FFFF)
      ok = 1'b0;
    unique case (fmt)
      F_I: dec.immed = {{20{instruction[31]}}, instruction[31:20]};
      F_S: dec.immed = {{20{instruction[31]}}, instruction[31:25],
                        instruction[11:7]};
      F_B: dec.immed = {{19{instruction[31]}}, instruction[31],
                        instruction[7], instruction[30:25],
                        instruction[11:8], 1'b0};
      F_U: dec.immed = {instruction[31:12], 12'h0};
      F_J: dec.immed = {{11{instruction[31]}}, instruction[31],
                        instruction[19:12], instruction[20],
                        instruction[30:21], 1'b0};
      default: dec.immed = 32'h0;
    endcase
    dec.rs3 = r4 ? instruction[31:27] : 5'd0;
    dec.ok  = ok;
    if (!ok) begin
      dec.unit  = U_SYS;
      dec.rd_we = 1'b0;
      dec.immed = 32'h0;
    end
  end

  assign out_valid = (occ != '0);
  assign pop       = out_valid && out_ready;
  assign in_ready  = (occ < FULL) || pop;
  assign push      = in_valid && in_ready && !flush;

  // queue pointers and occupancy; reset beats flush beats traffic
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      occ <= occ + OW'(1);
      else if (pop && !push) occ <= occ - OW'(1);
    end
  end

  // record storage, deliberately left unreset
  always_ff @(posedge clk) begin
    if (n_rst && push) mem[wr_ptr] <= dec;
  end

  assign head       = mem[rd_ptr];
  assign unit       = head.unit;
  assign funct3     = head.funct3;
  assign funct7     = head.funct7;
  assign reg_d      = head.rd;
  assign reg_s1     = head.rs1;
  assign reg_s2     = head.rs2;
  assign reg_s3     = head.rs3;
  assign rd_we      = head.rd_we;
  assign immed      = head.immed;
  assign pc_out     = head.pc;
  assign n_bad_inst = out_valid ? head.ok : 1'b1;
  assign occupancy  = occ;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed decode vectors, queue flow, flush, reset,
// and a table-driven stream with random stalls checked by scoreboard.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        in_valid;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic        flush;
  logic        out_ready;

  logic        in_ready, out_valid, rd_we, n_bad_inst;
  logic [1:0]  unit;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  reg_d, reg_s1, reg_s2, reg_s3;
  logic [31:0] immed, pc_out;
  logic [1:0]  occupancy;

  logic        b_in_ready, b_out_valid, b_rd_we, b_n_bad;
  logic [1:0]  b_unit;
  logic [2:0]  b_funct3;
  logic [6:0]  b_funct7;
  logic [4:0]  b_reg_d, b_reg_s1, b_reg_s2, b_reg_s3;
  logic [31:0] b_immed, b_pc_out;
  logic [1:0]  b_occ;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  decode_stage #(.DEPTH(2)) dut (
    .clk(clk), .n_rst(n_rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .instruction(instruction), .pc(pc), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .unit(unit), .funct3(funct3), .funct7(funct7),
    .reg_d(reg_d), .reg_s1(reg_s1), .reg_s2(reg_s2),
    .reg_s3(reg_s3), .rd_we(rd_we), .immed(immed),
    .pc_out(pc_out), .n_bad_inst(n_bad_inst),
    .occupancy(occupancy)
  );

  decode_stage #(
    .DEPTH(2), .EN_M(1'b0), .EN_A(1'b0), .EN_F(1'b0)
  ) dut_min (
    .clk(clk), .n_rst(n_rst),
    .in_valid(in_valid), .in_ready(b_in_ready),
    .instruction(instruction), .pc(pc), .flush(flush),
    .out_valid(b_out_valid), .out_ready(out_ready),
    .unit(b_unit), .funct3(b_funct3), .funct7(b_funct7),
    .reg_d(b_reg_d), .reg_s1(b_reg_s1), .reg_s2(b_reg_s2),
    .reg_s3(b_reg_s3), .rd_we(b_rd_we), .immed(b_immed),
    .pc_out(b_pc_out), .n_bad_inst(b_n_bad),
    .occupancy(b_occ)
  );

  typedef struct packed {
    logic [31:0] ins;
    logic [1:0]  unit;
    logic        we;
    logic [31:0] imm;
    logic [4:0]  rs3;
    logic        ok;
  } vec_t;

  typedef struct packed {
    logic [4:0]  k;
    logic [31:0] pc;
  } sb_t;

  localparam int NV = 17;
  vec_t tbl [NV];
  sb_t  sb [$];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] ins,
                       input logic [31:0] p);
    @(negedge clk);
    in_valid    = v;
    instruction = ins;
    pc          = p;
    #1;
  endtask

  initial begin
    tbl = '{
      '{32'h00500093, 2'd0, 1'b1, 32'd5,        5'd0, 1'b1},
      '{32'hFE20AE23, 2'd1, 1'b0, 32'hFFFFFFFC, 5'd0, 1'b1},
      '{32'h02208033, 2'd0, 1'b0, 32'd0,        5'd0, 1'b1},
      '{32'h00000000, 2'd3, 1'b0, 32'd0,        5'd0, 1'b0},
      '{32'hFFFFFFFF, 2'd3, 1'b0, 32'd0,        5'd0, 1'b0},
      '{32'h123452B7, 2'd0, 1'b1, 32'h12345000, 5'd0, 1'b1},
      '{32'h008000EF, 2'd0, 1'b1, 32'd8,        5'd0, 1'b1},
      '{32'h00000863, 2'd0, 1'b0, 32'd16,       5'd0, 1'b1},
      '{32'h42309093, 2'd3, 1'b0, 32'd0,        5'd0, 1'b0},
      '{32'h4030D093, 2'd0, 1'b1, 32'h403,      5'd0, 1'b1},
      '{32'h00812183, 2'd1, 1'b1, 32'd8,        5'd0, 1'b1},
      '{32'h00412087, 2'd1, 1'b1, 32'd4,        5'd0, 1'b1},
      '{32'h203100C3, 2'd2, 1'b1, 32'd0,        5'd4, 1'b1},
      '{32'h00000073, 2'd3, 1'b0, 32'd0,        5'd0, 1'b1},
      '{32'h00004501, 2'd3, 1'b0, 32'd0,        5'd0, 1'b0},
      '{32'h0021A0AF, 2'd1, 1'b1, 32'd0,        5'd0, 1'b1},
      '{32'h00000013, 2'd0, 1'b0, 32'd0,        5'd0, 1'b1}
    };
    n_rst = 1'b0; in_valid = 1'b0; instruction = '0;
    pc = '0; flush = 1'b0; out_ready = 1'b0;

    // reset
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ov", out_valid, 0);
    chk("rst_occ", occupancy, 0);
    chk("rst_nbad", n_bad_inst, 1);
    n_rst = 1'b1;
    @(negedge clk); #1;
    chk("rst_rdy", in_ready, 1);

    // addi x1,x0,5
    out_ready = 1'b1;
    drive(1'b1, 32'h00500093, 32'h100);
    drive(1'b0, 32'h0, 32'h0);
    chk("addi_ov", out_valid, 1);
    chk("addi_unit", unit, 0);
    chk("addi_rd", reg_d, 1);
    chk("addi_imm", immed, 5);
    chk("addi_we", rd_we, 1);
    chk("addi_ok", n_bad_inst, 1);
    chk("addi_pc", pc_out, 32'h100);

    // sw x2,-4(x1)
    drive(1'b1, 32'hFE20AE23, 32'h104);
    drive(1'b0, 32'h0, 32'h0);
    chk("sw_unit", unit, 1);
    chk("sw_imm", immed, 32'hFFFFFFFC);
    chk("sw_we", rd_we, 0);
    chk("sw_rs1", reg_s1, 1);
    chk("sw_rs2", reg_s2, 2);
    chk("sw_f3", funct3, 3'b010);

    // mul: legal with M, illegal without
    drive(1'b1, 32'h02208033, 32'h108);
    drive(1'b0, 32'h0, 32'h0);
    chk("mul_ok", n_bad_inst, 1);
    chk("mul_unit", unit, 0);
    chk("mul_f7", funct7, 7'b0000001);
    chk("mulm_ok", b_n_bad, 0);
    chk("mulm_unit", b_unit, 3);
    chk("mulm_we", b_rd_we, 0);

    // amo and flw with A/F disabled
    drive(1'b1, 32'h0021A0AF, 32'h10C);
    drive(1'b0, 32'h0, 32'h0);
    chk("amo_unit", unit, 1);
    chk("amom_ok", b_n_bad, 0);
    drive(1'b1, 32'h00412087, 32'h110);
    drive(1'b0, 32'h0, 32'h0);
    chk("flw_ok", n_bad_inst, 1);
    chk("flwm_unit", b_unit, 3);
    drive(1'b0, 32'h0, 32'h0);
    chk("empty_ov", out_valid, 0);
    chk("empty_nbad", n_bad_inst, 1);

    // full queue, then push and pop on the same edge
    out_ready = 1'b0;
    drive(1'b1, 32'h00500093, 32'hA0);
    drive(1'b1, 32'h00000013, 32'hA4);
    drive(1'b1, 32'h123452B7, 32'hA8);
    chk("full_rdy", in_ready, 0);
    chk("full_occ", occupancy, 2);
    @(negedge clk); #1;
    chk("stall_occ", occupancy, 2);
    chk("stall_pc", pc_out, 32'hA0);
    out_ready = 1'b1; #1;
    chk("pp_rdy", in_ready, 1);
    drive(1'b0, 32'h0, 32'h0);
    chk("pp_occ", occupancy, 2);
    chk("pp_pc1", pc_out, 32'hA4);
    @(negedge clk); #1;
    chk("pp_pc2", pc_out, 32'hA8);
    chk("pp_imm2", immed, 32'h12345000);
    chk("pp_occ1", occupancy, 1);
    @(negedge clk); #1;
    chk("pp_drain", out_valid, 0);

    // flush with in_valid high
    out_ready = 1'b0;
    drive(1'b1, 32'h00500093, 32'hB0);
    drive(1'b1, 32'h00500093, 32'hB4);
    @(negedge clk);
    flush = 1'b1;
    in_valid = 1'b1;
    instruction = 32'h00000013;
    pc = 32'hF0;
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("fl_occ", occupancy, 0);
    chk("fl_ov", out_valid, 0);
    out_ready = 1'b1;
    begin
      logic seen;
      seen = 1'b0;
      repeat (4) begin
        @(negedge clk); #1;
        if (out_valid) seen = 1'b1;
      end
      chk("fl_ghost", seen, 0);
    end

    // reset mid-stream dominates flush and in_valid
    out_ready = 1'b0;
    drive(1'b1, 32'h00500093, 32'hC0);
    drive(1'b1, 32'h00500093, 32'hC4);
    @(negedge clk);
    n_rst = 1'b0;
    flush = 1'b1;
    in_valid = 1'b1;
    @(negedge clk); #1;
    chk("mr_occ", occupancy, 0);
    chk("mr_ov", out_valid, 0);
    chk("mr_nbad", n_bad_inst, 1);
    n_rst = 1'b1;
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk); #1;
    chk("mr_ov2", out_valid, 0);
    chk("mr_rdy", in_ready, 1);

    // table-driven stream with random stalls
    begin
      int pushed;
      int cyc;
      int k;
      sb_t e;
      pushed = 0;
      cyc = 0;
      k = 0;
      while ((pushed < 200 || sb.size() != 0) && cyc < 4000) begin
        @(negedge clk);
        cyc++;
        k = $urandom_range(0, NV - 1);
        in_valid = (pushed < 200) && ($urandom_range(0, 3) != 0);
        instruction = tbl[k].ins;
        pc = 32'h1000 + 32'(pushed * 4);
        out_ready = ($urandom_range(0, 2) != 0);
        #1;
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            chk("sb_extra", out_valid, 0);
          end else begin
            vec_t v;
            logic [31:0] w;
            e = sb.pop_front();
            v = tbl[e.k];
            w = v.ins;
            chk("s_pc", pc_out, e.pc);
            chk("s_unit", unit, v.unit);
            chk("s_we", rd_we, v.we);
            chk("s_imm", immed, v.imm);
            chk("s_ok", n_bad_inst, v.ok);
            chk("s_rd", reg_d, w[11:7]);
            chk("s_rs3", reg_s3, v.rs3);
          end
        end
        if (in_valid && in_ready) begin
          sb.push_back('{k: 5'(k), pc: pc});
          pushed++;
        end
      end
      in_valid = 1'b0;
      chk("s_left", sb.size(), 0);
      chk("s_count", pushed, 200);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
